// File: rtl/decode_wb_ctrl_if.sv
// Bus bundle between decode_wb_ctrl, its instruction source, RegisterFile and ALU.
// The slave modport is the sequencer's view; master is the surrounding environment.
interface decode_wb_ctrl_if #(
    parameter int WIDTH = 16
);
    logic [15:0]      instr;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] rf_out1;
    logic [WIDTH-1:0] rf_out2;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       select1;
    logic [3:0]       select2;
    logic [4:0]       rf_enable;
    logic [WIDTH-1:0] rf_data_in;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [7:0]       alu_op;
    logic             done;

    modport slave (
        input  instr, instr_valid, rf_out1, rf_out2, alu_result,
        output instr_ready, select1, select2, rf_enable, rf_data_in,
               alu_a, alu_b, alu_op, done
    );

    modport master (
        output instr, instr_valid, rf_out1, rf_out2, alu_result,
        input  instr_ready, select1, select2, rf_enable, rf_data_in,
               alu_a, alu_b, alu_op, done
    );
endinterface

// File: rtl/decode_wb_ctrl.sv
// Decode / writeback sequencer in front of RegisterFile: IDLE -> READ -> EXEC -> WB,
// one instruction in flight, one RegisterFile write per writing instruction.
module decode_wb_ctrl #(
    parameter int           WIDTH   = 16,
    parameter logic [4:0]   NOWRITE = 5'b10000
) (
    input logic             clk,
    input logic             reset,
    decode_wb_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WB
    } state_t;

    state_t           state_q, state_d;
    logic [15:0]      instr_q, instr_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [7:0]       alu_op_q, alu_op_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic [3:0]       opcode, rdest, opext, rsrc;
    logic [7:0]       imm;
    logic [WIDTH-1:0] imm_ext;
    logic             writes;

    assign opcode = instr_q[15:12];
    assign rdest  = instr_q[11:8];
    assign opext  = instr_q[7:4];
    assign rsrc   = instr_q[3:0];
    assign imm    = instr_q[7:0];

    always_comb begin
        imm_ext = '0;
        case (opcode)
            4'h5, 4'h9, 4'hB, 4'hD: imm_ext = {{(WIDTH-8){imm[7]}}, imm};
            4'h1, 4'h2, 4'h3:       imm_ext = WIDTH'(imm);
            4'hF:                   imm_ext = WIDTH'(imm) << 8;
            default:                imm_ext = WIDTH'(imm);
        endcase
    end

    // CMP (0000/1011), CMPI (1011) and unlisted opcodes never write back.
    always_comb begin
        writes = 1'b0;
        case (opcode)
            4'h0:                                   writes = (opext != 4'hB);
            4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hD, 4'hF: writes = 1'b1;
            default:                                writes = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        alu_op_d = alu_op_q;
        data_d   = data_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                alu_a_d  = bus.rf_out1;
                alu_b_d  = (opcode == 4'h0) ? bus.rf_out2 : imm_ext;
                alu_op_d = {opcode, opext};
                state_d  = ST_EXEC;
            end
            ST_EXEC: begin
                data_d  = bus.alu_result;
                state_d = ST_WB;
            end
            ST_WB: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            alu_op_q <= alu_op_d;
            data_q   <= data_d;
        end
    end

    // Gated by reset directly so a reset landing on WB suppresses that edge's write.
    assign bus.instr_ready = (state_q == ST_IDLE) && reset;
    assign bus.done        = (state_q == ST_WB) && reset;
    assign bus.rf_enable   = ((state_q == ST_WB) && reset && writes) ? {1'b0, rdest} : NOWRITE;
    assign bus.select1     = rdest;
    assign bus.select2     = rsrc;
    assign bus.rf_data_in  = data_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
endmodule

// File: tb/tb_decode_wb_ctrl.sv
// Directed bench for decode_wb_ctrl with a behavioural RegisterFile and adder ALU.
module tb_decode_wb_ctrl;
    localparam logic [4:0] NW = 5'b10000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    decode_wb_ctrl_if #(.WIDTH(16)) bus ();

    decode_wb_ctrl #(.WIDTH(16), .NOWRITE(5'b10000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] rf [16];
    logic        pre_we;
    logic [3:0]  pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (pre_we) rf[pre_addr] <= pre_data;
        else if (!bus.rf_enable[4]) rf[bus.rf_enable[3:0]] <= bus.rf_data_in;
    end

    assign bus.rf_out1    = rf[bus.select1];
    assign bus.rf_out2    = rf[bus.select2];
    assign bus.alu_result = bus.alu_a + bus.alu_b;

    int passed = 0;
    int total  = 0;

    task automatic set_reg(input logic [3:0] a, input logic [15:0] v);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Presents one instruction and returns at the negedge of the READ cycle.
    task automatic send(input logic [15:0] ins);
        bus.instr = ins;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; bus.instr_valid = 1'b0; bus.instr = '0; pre_we = 1'b0;
        repeat (5) @(negedge clk);
        total++; if (bus.rf_enable !== NW) $display("FAIL reset_enable: got %b want %b", bus.rf_enable, NW); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done); else passed++;
        total++; if (bus.instr_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.instr_ready); else passed++;
        total++; if (bus.select1 !== 4'h0) $display("FAIL reset_select1: got %h want 0", bus.select1); else passed++;
        total++; if (bus.alu_a !== 16'h0) $display("FAIL reset_alu_a: got %h want 0", bus.alu_a); else passed++;
        total++; if (bus.alu_op !== 8'h0) $display("FAIL reset_alu_op: got %h want 0", bus.alu_op); else passed++;
        total++; if (bus.rf_data_in !== 16'h0) $display("FAIL reset_data: got %h want 0", bus.rf_data_in); else passed++;
        reset = 1'b1;
        #1;
        total++; if (bus.instr_ready !== 1'b1) $display("FAIL release_ready: got %b want 1", bus.instr_ready); else passed++;
        @(negedge clk);
    endtask

    task automatic test_add();
        set_reg(4'd3, 16'd10);
        set_reg(4'd5, 16'd20);
        total++; if (bus.instr_ready !== 1'b1) $display("FAIL add_ready_idle: got %b want 1", bus.instr_ready); else passed++;
        send(16'h0355);
        total++; if (bus.select1 !== 4'd3) $display("FAIL add_select1: got %h want 3", bus.select1); else passed++;
        total++; if (bus.select2 !== 4'd5) $display("FAIL add_select2: got %h want 5", bus.select2); else passed++;
        total++; if (bus.instr_ready !== 1'b0) $display("FAIL add_ready_busy: got %b want 0", bus.instr_ready); else passed++;
        total++; if (bus.rf_enable !== NW) $display("FAIL add_enable_read: got %b want %b", bus.rf_enable, NW); else passed++;
        @(negedge clk);
        total++; if (bus.alu_a !== 16'd10) $display("FAIL add_alu_a: got %0d want 10", bus.alu_a); else passed++;
        total++; if (bus.alu_b !== 16'd20) $display("FAIL add_alu_b: got %0d want 20", bus.alu_b); else passed++;
        total++; if (bus.alu_op !== 8'h05) $display("FAIL add_alu_op: got %h want 05", bus.alu_op); else passed++;
        total++; if (bus.rf_enable !== NW) $display("FAIL add_enable_exec: got %b want %b", bus.rf_enable, NW); else passed++;
        @(negedge clk);
        total++; if (bus.rf_enable !== 5'b00011) $display("FAIL add_enable_wb: got %b want 00011", bus.rf_enable); else passed++;
        total++; if (bus.rf_data_in !== 16'd30) $display("FAIL add_data_wb: got %0d want 30", bus.rf_data_in); else passed++;
        total++; if (bus.done !== 1'b1) $display("FAIL add_done_wb: got %b want 1", bus.done); else passed++;
        @(negedge clk);
        total++; if (bus.done !== 1'b0) $display("FAIL add_done_after: got %b want 0", bus.done); else passed++;
        total++; if (bus.rf_enable !== NW) $display("FAIL add_enable_after: got %b want %b", bus.rf_enable, NW); else passed++;
        total++; if (bus.instr_ready !== 1'b1) $display("FAIL add_ready_after: got %b want 1", bus.instr_ready); else passed++;
        total++; if (rf[3] !== 16'd30) $display("FAIL add_rf_r3: got %0d want 30", rf[3]); else passed++;
    endtask

    task automatic test_imm();
        logic [15:0] ins  [3] = '{16'h52FF, 16'h12FF, 16'hF1AB};
        logic [15:0] expb [3] = '{16'hFFFF, 16'h00FF, 16'hAB00};
        logic [7:0]  expo [3] = '{8'h5F, 8'h1F, 8'hFA};
        logic [4:0]  expe [3] = '{5'b00010, 5'b00010, 5'b00001};
        for (int i = 0; i < 3; i++) begin
            send(ins[i]);
            @(negedge clk);
            total++; if (bus.alu_b !== expb[i]) $display("FAIL imm_alu_b[%0d]: got %h want %h", i, bus.alu_b, expb[i]); else passed++;
            total++; if (bus.alu_op !== expo[i]) $display("FAIL imm_alu_op[%0d]: got %h want %h", i, bus.alu_op, expo[i]); else passed++;
            @(negedge clk);
            total++; if (bus.rf_enable !== expe[i]) $display("FAIL imm_enable[%0d]: got %b want %b", i, bus.rf_enable, expe[i]); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_nowrite();
        logic [15:0] ins [2] = '{16'h04B7, 16'hB405};
        set_reg(4'd4, 16'h1234);
        for (int i = 0; i < 2; i++) begin
            send(ins[i]);
            total++; if (bus.rf_enable !== NW) $display("FAIL nowr_enable_read[%0d]: got %b want %b", i, bus.rf_enable, NW); else passed++;
            @(negedge clk);
            total++; if (bus.rf_enable !== NW) $display("FAIL nowr_enable_exec[%0d]: got %b want %b", i, bus.rf_enable, NW); else passed++;
            @(negedge clk);
            total++; if (bus.rf_enable !== NW) $display("FAIL nowr_enable_wb[%0d]: got %b want %b", i, bus.rf_enable, NW); else passed++;
            total++; if (bus.done !== 1'b1) $display("FAIL nowr_done[%0d]: got %b want 1", i, bus.done); else passed++;
            @(negedge clk);
            total++; if (rf[4] !== 16'h1234) $display("FAIL nowr_rf_r4[%0d]: got %h want 1234", i, rf[4]); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ins [3] = '{16'h0677, 16'h5805, 16'h0906};
        logic [15:0] tmp;
        set_reg(4'd6, 16'd100);
        set_reg(4'd7, 16'd7);
        set_reg(4'd8, 16'd50);
        set_reg(4'd9, 16'd1);
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tmp = ins[k];
            bus.instr = tmp;
            total++; if (bus.instr_ready !== 1'b1) $display("FAIL b2b_ready_idle[%0d]: got %b want 1", k, bus.instr_ready); else passed++;
            @(posedge clk);
            @(negedge clk);
            if (k < 2) bus.instr = ins[k+1];
            else bus.instr_valid = 1'b0;
            total++; if (bus.instr_ready !== 1'b0) $display("FAIL b2b_ready_busy[%0d]: got %b want 0", k, bus.instr_ready); else passed++;
            @(negedge clk);
            @(negedge clk);
            total++; if (bus.select1 !== tmp[11:8]) $display("FAIL b2b_select1_wb[%0d]: got %h want %h", k, bus.select1, tmp[11:8]); else passed++;
            total++; if (bus.done !== 1'b1) $display("FAIL b2b_done[%0d]: got %b want 1", k, bus.done); else passed++;
            @(negedge clk);
        end
        total++; if (rf[6] !== 16'd107) $display("FAIL b2b_rf_r6: got %0d want 107", rf[6]); else passed++;
        total++; if (rf[8] !== 16'd55) $display("FAIL b2b_rf_r8: got %0d want 55", rf[8]); else passed++;
        total++; if (rf[9] !== 16'd108) $display("FAIL b2b_rf_r9: got %0d want 108", rf[9]); else passed++;
    endtask

    task automatic test_reset_exec();
        set_reg(4'd3, 16'h0040);
        set_reg(4'd5, 16'h0001);
        send(16'h0355);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (bus.instr_ready !== 1'b0) $display("FAIL rexec_ready: got %b want 0", bus.instr_ready); else passed++;
        total++; if (bus.rf_enable !== NW) $display("FAIL rexec_enable: got %b want %b", bus.rf_enable, NW); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL rexec_done: got %b want 0", bus.done); else passed++;
        reset = 1'b1;
        @(negedge clk);
        total++; if (rf[3] !== 16'h0040) $display("FAIL rexec_rf_r3: got %h want 0040", rf[3]); else passed++;
        total++; if (bus.instr_ready !== 1'b1) $display("FAIL rexec_ready_after: got %b want 1", bus.instr_ready); else passed++;
        send(16'h0355);
        @(negedge clk);
        total++; if (bus.alu_a !== 16'h0040) $display("FAIL rexec_next_alu_a: got %h want 0040", bus.alu_a); else passed++;
        @(negedge clk);
        total++; if (bus.rf_data_in !== 16'h0041) $display("FAIL rexec_next_data: got %h want 0041", bus.rf_data_in); else passed++;
        @(negedge clk);
        total++; if (rf[3] !== 16'h0041) $display("FAIL rexec_next_rf_r3: got %h want 0041", rf[3]); else passed++;
    endtask

    task automatic test_reset_wb();
        send(16'h0355);
        @(negedge clk);
        @(negedge clk);
        total++; if (bus.rf_enable !== 5'b00011) $display("FAIL rwb_enable_pre: got %b want 00011", bus.rf_enable); else passed++;
        reset = 1'b0;
        #1;
        total++; if (bus.rf_enable !== NW) $display("FAIL rwb_enable_forced: got %b want %b", bus.rf_enable, NW); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL rwb_done_forced: got %b want 0", bus.done); else passed++;
        @(negedge clk);
        total++; if (rf[3] !== 16'h0041) $display("FAIL rwb_rf_r3: got %h want 0041", rf[3]); else passed++;
        total++; if (bus.rf_data_in !== 16'h0) $display("FAIL rwb_data_cleared: got %h want 0", bus.rf_data_in); else passed++;
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.instr_ready !== 1'b1) $display("FAIL rwb_ready_after: got %b want 1", bus.instr_ready); else passed++;
        send(16'h5302);
        @(negedge clk);
        total++; if (bus.alu_b !== 16'h0002) $display("FAIL rwb_next_alu_b: got %h want 0002", bus.alu_b); else passed++;
        @(negedge clk);
        total++; if (bus.rf_data_in !== 16'h0043) $display("FAIL rwb_next_data: got %h want 0043", bus.rf_data_in); else passed++;
        @(negedge clk);
        total++; if (rf[3] !== 16'h0043) $display("FAIL rwb_next_rf_r3: got %h want 0043", rf[3]); else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_imm();
        test_nowrite();
        test_back_to_back();
        test_reset_exec();
        test_reset_wb();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
